// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Shares one external asynchronous SRAM between the VGA scan-out
//            reader (read-only, priority) and the text renderer (read/write).
//            Sequences each access as IDLE -> SETUP -> ACCESS x N -> RECOVER,
//            owns the data-bus direction and bounds renderer starvation.
//            Optional grant statistics are compiled in with the macro
//            SRAM_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W        = 20,
    parameter int DATA_W        = 32,
    parameter int ACCESS_CYCLES = 2,
    parameter int MAX_STARVE    = 4
) (
    input  logic              clk,
    input  logic              rst,
    // VGA scan-out port (read-only)
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_ack,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_rvalid,
    // Renderer port (read/write)
    input  logic              rnd_req,
    input  logic              rnd_we,
    input  logic [ADDR_W-1:0] rnd_addr,
    input  logic [DATA_W-1:0] rnd_wdata,
    output logic              rnd_ack,
    output logic [DATA_W-1:0] rnd_rdata,
    output logic              rnd_rvalid,
    // SRAM pins
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]       stat_vga_grants,
    output logic [31:0]       stat_rnd_grants,
    output logic [15:0]       stat_forced
`endif
);

    // ACCESS-phase counter only needs to reach ACCESS_CYCLES-1; keep it at
    // least one bit wide so a single-cycle access still elaborates.
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    // Starvation counter saturates at MAX_STARVE.
    localparam int STV_W = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(MAX_STARVE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        ACCESS  = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [CNT_W-1:0]   r_cnt;
    logic [STV_W-1:0]   r_starve;
    logic               r_we;       // latched direction of the access in flight
    logic               r_owner;    // 0 = VGA, 1 = renderer
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_vga_rdata;
    logic [DATA_W-1:0]  r_rnd_rdata;

    logic               w_grant_vga;
    logic               w_grant_rnd;
    logic               w_forced;
    logic               w_busy;
    logic               w_last_access;

    assign w_busy        = (r_state != IDLE);
    assign w_last_access = (r_state == ACCESS) && (r_cnt == CNT_LAST);

    // State register; reset aborts any access in flight immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and IDLE-cycle arbitration (starved renderer, then VGA, then renderer).
    always_comb begin
        w_next      = r_state;
        w_grant_vga = 1'b0;
        w_grant_rnd = 1'b0;
        w_forced    = 1'b0;
        case (r_state)
            IDLE: begin
                if ((r_starve == STV_MAX) && rnd_req) begin
                    w_grant_rnd = 1'b1;
                    w_forced    = 1'b1;
                end else if (vga_req) begin
                    w_grant_vga = 1'b1;
                end else if (rnd_req) begin
                    w_grant_rnd = 1'b1;
                end
                if (w_grant_vga || w_grant_rnd) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                w_next = ACCESS;
            end
            ACCESS: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = RECOVER;
                end
            end
            RECOVER: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Latch the granted request so the requester is free to move on after ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_owner <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_grant_vga) begin
            r_we    <= 1'b0;
            r_owner <= 1'b0;
            r_addr  <= vga_addr;
        end else if (w_grant_rnd) begin
            r_we    <= rnd_we;
            r_owner <= 1'b1;
            r_addr  <= rnd_addr;
            r_wdata <= rnd_wdata;
        end
    end

    // Count strobe-active cycles; restarted in SETUP so every access is the same length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ACCESS) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Starvation counter: bumps when VGA wins over a waiting renderer, clears on renderer grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_grant_rnd) begin
            r_starve <= '0;
        end else if (w_grant_vga && rnd_req && (r_starve != STV_MAX)) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    // Capture read data at the end of the strobe window into the owner's return register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vga_rdata <= '0;
            r_rnd_rdata <= '0;
        end else if (w_last_access && !r_we) begin
            if (r_owner) begin
                r_rnd_rdata <= sram_din;
            end else begin
                r_vga_rdata <= sram_din;
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    logic [31:0] r_stat_vga;
    logic [31:0] r_stat_rnd;
    logic [15:0] r_stat_forced;

    // Free-running wrapping grant counters for performance monitoring.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_vga    <= '0;
            r_stat_rnd    <= '0;
            r_stat_forced <= '0;
        end else begin
            if (w_grant_vga) begin
                r_stat_vga <= r_stat_vga + 32'd1;
            end
            if (w_grant_rnd) begin
                r_stat_rnd <= r_stat_rnd + 32'd1;
            end
            if (w_forced) begin
                r_stat_forced <= r_stat_forced + 16'd1;
            end
        end
    end

    assign stat_vga_grants = r_stat_vga;
    assign stat_rnd_grants = r_stat_rnd;
    assign stat_forced     = r_stat_forced;
`endif

    // Acks are only possible in IDLE because grants are only decoded there.
    assign vga_ack    = w_grant_vga;
    assign rnd_ack    = w_grant_rnd;

    // Return data is presented during RECOVER of a read, to the owning port only.
    assign vga_rdata  = r_vga_rdata;
    assign rnd_rdata  = r_rnd_rdata;
    assign vga_rvalid = (r_state == RECOVER) && !r_we && !r_owner;
    assign rnd_rvalid = (r_state == RECOVER) && !r_we &&  r_owner;

    // Pin decode straight from the state register: everything returns inactive
    // the moment the asynchronous reset clears the state.
    // Output enable and bus drive are mutually exclusive because both depend
    // on the latched direction r_we.
    assign sram_addr  = r_addr;
    assign sram_dout  = r_wdata;
    assign sram_ce_n  = !w_busy;
    assign sram_oe_n  = !(((r_state == SETUP) || (r_state == ACCESS)) && !r_we);
    assign sram_we_n  = !((r_state == ACCESS) && r_we);
    assign sram_dq_oe = w_busy && r_we;

endmodule
`default_nettype wire
